sparc_mem_unit: RTL and testbench

//  Byte-addressed, big-endian data/instruction memory serving the SPARC control unit's RAM_enable/RAM_OpCode/MFC handshake.

---
 rtl/sparc_mem_pkg.sv | 45 ++++
 rtl/sparc_mem_lane.sv | 46 ++++
 rtl/sparc_mem_unit.sv | 157 +++++++++++++++
 tb/tb_sparc_mem_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC memory unit: op3 codes, FSM states, access sizes
// and the op3 decoder used by the top level.
package sparc_mem_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        size_t size;
        logic  is_signed;
        logic  is_store;
        logic  legal;
    } op_info_t;

    function automatic op_info_t decode_op3(input logic [5:0] op3);
        op_info_t info;
        info.size      = SZ_W;
        info.is_signed = 1'b0;
        info.is_store  = 1'b0;
        info.legal     = 1'b1;
        case (op3)
            OP_LD:   info.size = SZ_W;
            OP_LDUB: info.size = SZ_B;
            OP_LDUH: info.size = SZ_H;
            OP_LDSB: begin info.size = SZ_B; info.is_signed = 1'b1; end
            OP_LDSH: begin info.size = SZ_H; info.is_signed = 1'b1; end
            OP_ST:   begin info.size = SZ_W; info.is_store  = 1'b1; end
            OP_STB:  begin info.size = SZ_B; info.is_store  = 1'b1; end
            OP_STH:  begin info.size = SZ_H; info.is_store  = 1'b1; end
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/sparc_mem_lane.sv
// Big-endian lane steering: extracts and extends load data from an aligned word,
// and builds byte enables plus replicated write data for stores.
module sparc_mem_lane
    import sparc_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_word
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // NOTE: every output of a combinational block gets a default first so no path
    // through the if/case leaves it unassigned, which would infer a latch.
    always_comb begin
        case (lane)
            2'd0: rd_byte = rd_word[31:24];
            2'd1: rd_byte = rd_word[23:16];
            2'd2: rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = lane[1] ? rd_word[15:0] : rd_word[31:16];

        ld_data = rd_word;
        wr_be   = 4'b1111;
        wr_word = st_data;

        // Byte enable bit 3 is the lowest address of the word (big-endian).
        if (size == SZ_B) begin
            ld_data = is_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            wr_be   = 4'b1000 >> lane;
            wr_word = {4{st_data[7:0]}};
        end else if (size == SZ_H) begin
            ld_data = is_signed ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            wr_be   = lane[1] ? 4'b0011 : 4'b1100;
            wr_word = {2{st_data[15:0]}};
        end
    end

endmodule

// File: rtl/sparc_mem_unit.sv
// Byte-addressed big-endian memory with RAM_enable/MFC handshake and programmable wait.
// Define MEM_ALIGN_CHECK_EN to fault misaligned accesses instead of forcing alignment.
module sparc_mem_unit
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] MAR_Out,
    input  logic [31:0] MDR_Out,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MSET
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                 state, next_state;
    logic [3:0]             wait_cnt;
    logic [5:0]             req_op;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [31:0]            req_data;
    logic                   fault;

    logic [7:0]             mem [DEPTH];

    op_info_t               info;
    logic [ADDR_BITS-1:0]   eff_addr;
    logic [ADDR_BITS-3:0]   word_idx;
    logic                   misaligned;
    logic                   access_err;
    logic                   accept;
    logic                   do_access;
    logic [31:0]            rd_word;
    logic [31:0]            ld_data;
    logic [31:0]            wr_word;
    logic [3:0]             wr_be;

    // Address bits above the implemented array are ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^MAR_Out[31:ADDR_BITS];

    assign info = decode_op3(req_op);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (info.size == SZ_W && req_addr[1:0] != 2'b00) ||
                        (info.size == SZ_H && req_addr[0]);
    assign eff_addr   = req_addr;
`else
    assign misaligned = 1'b0;
    always_comb begin
        eff_addr = req_addr;
        if (info.size == SZ_W)
            eff_addr[1:0] = 2'b00;
        else if (info.size == SZ_H)
            eff_addr[0] = 1'b0;
    end
`endif

    assign access_err = !info.legal || misaligned;
    assign word_idx   = eff_addr[ADDR_BITS-1:2];
    assign rd_word    = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                         mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

    sparc_mem_lane u_lane (
        .size      (info.size),
        .is_signed (info.is_signed),
        .lane      (eff_addr[1:0]),
        .rd_word   (rd_word),
        .st_data   (req_data),
        .ld_data   (ld_data),
        .wr_be     (wr_be),
        .wr_word   (wr_word)
    );

    // NOTE: sequential state uses non-blocking assignment so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge Clk) begin
        if (RESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (RAM_enable) begin
                    accept     = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    do_access  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!RAM_enable)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            wait_cnt <= 4'd0;
            req_op   <= 6'd0;
            req_addr <= '0;
            req_data <= 32'd0;
            DataOut  <= 32'd0;
            fault    <= 1'b0;
        end else begin
            if (accept) begin
                req_op   <= RAM_OpCode;
                req_addr <= MAR_Out[ADDR_BITS-1:0];
                req_data <= MDR_Out;
                wait_cnt <= CNT_LOAD;
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (do_access) begin
                fault <= access_err;
                if (!info.is_store && !access_err)
                    DataOut <= ld_data;
            end else if (state == DONE && !RAM_enable) begin
                fault <= 1'b0;
            end
        end
    end

    // NOTE: the byte array has no reset; clearing a RAM needs a per-word write
    // sequence and would prevent mapping it onto memory macros.
    always_ff @(posedge Clk) begin
        if (!RESET && do_access && info.is_store && !access_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[3-k])
                    mem[{word_idx, 2'(k)}] <= wr_word[8*(3-k) +: 8];
            end
        end
    end

    assign MFC  = (state == DONE);
    assign MSET = fault;

endmodule

// File: tb/tb_sparc_mem_unit.sv
// Scoreboard bench for sparc_mem_unit: stimulus queues expected responses, a monitor
// pops and compares them on each MFC rising edge. Honours MEM_ALIGN_CHECK_EN.
module tb_sparc_mem_unit;

    localparam int WAIT_CYCLES = 2;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic        MIS_FAULT   = 1'b1;
    localparam logic [31:0] MIS_LD_DOUT = 32'h1234BE55;
    localparam logic [31:0] MIS_ST_DOUT = 32'h1234BE55;
    localparam logic [31:0] MIS_WORD    = 32'hCAFEF00D;
    localparam logic [31:0] MIS_LH_DOUT = 32'hCAFEF00D;
`else
    localparam logic        MIS_FAULT   = 1'b0;
    localparam logic [31:0] MIS_LD_DOUT = 32'hCAFEF00D;
    localparam logic [31:0] MIS_ST_DOUT = 32'hCAFEF00D;
    localparam logic [31:0] MIS_WORD    = 32'h11111111;
    localparam logic [31:0] MIS_LH_DOUT = 32'h00001111;
`endif

    logic        Clk = 1'b0;
    logic        RESET = 1'b1;
    logic        RAM_enable = 1'b1;
    logic [5:0]  RAM_OpCode = 6'd0;
    logic [31:0] MAR_Out = 32'd0;
    logic [31:0] MDR_Out = 32'd0;
    logic [31:0] DataOut;
    logic        MFC;
    logic        MSET;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        mset;
    } resp_t;

    resp_t exp_q[$];
    resp_t got;
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  mfc_prev = 1'b0;

    sparc_mem_unit #(.ADDR_BITS(9), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .Clk        (Clk),
        .RESET      (RESET),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .MAR_Out    (MAR_Out),
        .MDR_Out    (MDR_Out),
        .DataOut    (DataOut),
        .MFC        (MFC),
        .MSET       (MSET)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: one expected response per completed access.
    always @(negedge Clk) begin
        if (MFC === 1'b1 && !mfc_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mfc: got MFC=1 with no access outstanding, expected none");
            end else begin
                got = exp_q.pop_front();
                check({got.name, " dataout"}, DataOut, got.data);
                check({got.name, " mset"}, {31'd0, MSET}, {31'd0, got.mset});
            end
        end
        mfc_prev = (MFC === 1'b1);
    end

    // One handshake; hold = extra cycles RAM_enable stays high once MFC is seen.
    task automatic access(input string name, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_mset, input int hold);
        resp_t e;
        int    n;
        e.name = name;
        e.data = exp_data;
        e.mset = exp_mset;
        exp_q.push_back(e);
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = op;
        MAR_Out    = addr;
        MDR_Out    = wdata;
        @(posedge Clk);
        n = 1;
        @(negedge Clk);
        RAM_OpCode = 6'($urandom);
        MAR_Out    = $urandom;
        MDR_Out    = $urandom;
        if (hold == 0)
            RAM_enable = 1'b0;
        while (MFC !== 1'b1 && n < 40) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
        end
        check({name, " latency"}, n, WAIT_CYCLES + 1);
        repeat (hold) begin
            @(posedge Clk);
            @(negedge Clk);
            check({name, " mfc_hold"}, {31'd0, MFC}, 32'd1);
        end
        RAM_enable = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check({name, " mfc_fall"}, {31'd0, MFC}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with enable high.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset dataout", DataOut, 32'd0);
        check("reset mfc", {31'd0, MFC}, 32'd0);
        check("reset mset", {31'd0, MSET}, 32'd0);
        RESET      = 1'b0;
        RAM_enable = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("post-reset idle mfc", {31'd0, MFC}, 32'd0);

        // Basic store and sized loads.
        access("st_deadbeef", OP_ST,   32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 0);
        access("ld_10",       OP_LD,   32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        access("ldub_11",     OP_LDUB, 32'h11, 32'h0,        32'h000000AD, 1'b0, 0);
        access("ldsb_10",     OP_LDSB, 32'h10, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
        access("ldsh_12",     OP_LDSH, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
        access("lduh_12",     OP_LDUH, 32'h12, 32'h0,        32'h0000BEEF, 1'b0, 0);

        // Partial stores leave other bytes intact.
        access("stb_13",      OP_STB,  32'h13, 32'hAAAAAA55, 32'h0000BEEF, 1'b0, 0);
        access("ld_after_stb",OP_LD,   32'h10, 32'h0,        32'hDEADBE55, 1'b0, 0);
        access("ldsb_pos_13", OP_LDSB, 32'h13, 32'h0,        32'h00000055, 1'b0, 0);
        access("sth_10",      OP_STH,  32'h10, 32'hFFFF1234, 32'h00000055, 1'b0, 0);
        access("ld_after_sth",OP_LD,   32'h10, 32'h0,        32'h1234BE55, 1'b0, 0);
        access("ld_wrap_210", OP_LD,   32'h210, 32'h0,       32'h1234BE55, 1'b0, 0);

        // Enable held high through DONE; no second access may start.
        access("ld_hold",     OP_LD,   32'h10, 32'h0,        32'h1234BE55, 1'b0, 3);

        // Misalignment behaviour depends on the build.
        access("st_cafef00d", OP_ST,   32'h20, 32'hCAFEF00D, 32'h1234BE55, 1'b0, 0);
        access("ld_mis_22",   OP_LD,   32'h22, 32'h0,        MIS_LD_DOUT,  MIS_FAULT, 0);
        access("st_mis_21",   OP_ST,   32'h21, 32'h11111111, MIS_ST_DOUT,  MIS_FAULT, 0);
        access("ld_20_after", OP_LD,   32'h20, 32'h0,        MIS_WORD,     1'b0, 0);
        access("lduh_mis_21", OP_LDUH, 32'h21, 32'h0,        MIS_LH_DOUT,  MIS_FAULT, 0);

        // Illegal op3 faults and writes nothing.
        access("illegal_op",  OP_BAD,  32'h10, 32'hFFFFFFFF, MIS_LH_DOUT,  1'b1, 0);
        access("ld_after_bad",OP_LD,   32'h10, 32'h0,        32'h1234BE55, 1'b0, 0);

        // Reset landing on the access edge of a store aborts it.
        access("st_30",       OP_ST,   32'h30, 32'h0BADF00D, 32'h1234BE55, 1'b0, 0);
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = OP_ST;
        MAR_Out    = 32'h30;
        MDR_Out    = 32'h99999999;
        @(posedge Clk);
        @(negedge Clk);
        RAM_enable = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        RESET = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("abort mfc", {31'd0, MFC}, 32'd0);
        check("abort dataout", DataOut, 32'd0);
        RESET = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("abort stays idle", {31'd0, MFC}, 32'd0);
        access("ld_30_after_abort", OP_LD, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, 0);

        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
